seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor of the team's 16-bit combinational ALU. It keeps the same 4-bit opcode map, widens the datapath via WIDTH, and adds signed compare, arithmetic shift and an iterative divider.
- Multiply is iterative by default, with an optional single-cycle mode.
- Sits between the register-read and writeback stages. It is the only execute unit, so writeback must honour its output handshake.

Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of 2).
- FAST_MUL, 0, 1 = multiply completes in one cycle like the logic ops; 0 = shift-add, WIDTH cycles.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  synchronous, active-low reset.
- inValid  input  1  operands and opcode valid.
- inReady  output  1  unit can accept this cycle.
- aluOp  input  4  opcode.
- aIn  input  WIDTH  operand A.
- bIn  input  WIDTH  operand B.
- outValid  output  1  result registers valid.
- outReady  input  1  consumer takes the result this cycle.
- outPut  output  WIDTH  result.
- outHi  output  WIDTH  multiply high half; 0 for other ops.
- isZero  output  1  outPut == 0.
- carryOut  output  1  add carry / sub borrow.
- overflow  output  1  signed add/sub overflow, or mult with nonzero high half.
- divByZero  output  1  div/rem issued with bIn == 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: sampled on the clk edge while resetN == 0.
- Reset values: state=IDLE, outValid=0, outPut=0, outHi=0, all flags 0. inReady=0 while resetN low.
- Reset mid-operation aborts any in-flight mult/div. The result is discarded; no outValid.
- Accept: an operation is accepted on an edge where inValid && inReady. aIn, bIn and aluOp are captured; the inputs may change afterwards.
- inReady = resetN && state!=BUSY && (!outValid || outReady).
- Output handshake: the result is consumed on an edge where outValid && outReady.
  - outPut, outHi and the flags hold stable while outValid && !outReady.
  - A simultaneous consume and accept of a single-cycle op gives back-to-back results, one per cycle.
- Opcodes. All shifts use the full bIn as the amount; an amount ≥ WIDTH gives 0 (sra gives all sign bits).
  - 0000 add.
  - 0001 or.
  - 0010 xor.
  - 0011 and.
  - 0100 nor.
  - 0101 logical right shift aIn>>bIn.
  - 0110 left shift aIn<<bIn.
  - 0111 sub aIn-bIn.
  - 1000 nand.
  - 1001 mult unsigned: outPut = low half, outHi = high half of the 2*WIDTH product.
  - 1010 divu: quotient.
  - 1011 remu: remainder.
  - 1100 sra: arithmetic right shift.
  - 1101 slt signed: outPut = 1 if $signed(aIn) < $signed(bIn), else 0.
  - 1110 eq0: outPut = 1 if aIn == 0, else 0.
  - 1111 sltu: outPut = 1 if aIn < bIn unsigned, else 0.
- Latency for single-cycle ops (all except mult with FAST_MUL=0, divu, remu): outValid rises on the edge after accept.
- Latency for multi-cycle ops: accept moves IDLE→BUSY and loads a counter with WIDTH.
  - One product or quotient bit is resolved per cycle.
  - The counter decrements each BUSY cycle. When it reaches 0, the result registers load, state→IDLE and outValid=1.
  - outValid is seen exactly WIDTH+1 edges after accept. inReady=0 throughout BUSY.
- Division: restoring, unsigned.
  - With bIn == 0 there is no iteration: 1-cycle latency, quotient = all ones, remainder = aIn, divByZero=1.
- Flags are registered with the result and refer only to it.
  - carryOut: add = bit WIDTH of aIn+bIn; sub = 1 when aIn < bIn unsigned; 0 for all other ops.
  - overflow: add/sub signed overflow; mult = (outHi != 0); 0 otherwise.
  - isZero: valid for every op.
- The FSM has two states, IDLE and BUSY. The "result held" condition is the outValid register, not a separate state.

Test Plan:
- Reset: hold resetN=0 for 3 edges while inValid=1 → inReady=0, outValid=0, outPut=0, flags 0; first accept possible on the edge after resetN=1.
- Add overflow, WIDTH=16: add 0x7FFF+0x0001 → outPut 0x8000, overflow=1, carryOut=0; add 0xFFFF+0x0001 → outPut 0, isZero=1, carryOut=1, overflow=0; both results 1 cycle after accept.
- Back-to-back with backpressure: stream xor, nor, sra(0x8000,4), slt(0xFFFF,0x0001) with outReady=1 → results 1 per cycle: ..., 0xF800, 1; then drop outReady for 3 cycles → outPut holds and inReady=0.
- Multiply, FAST_MUL=0: mult 0x1234*0x0100 → outValid exactly 17 edges after accept, outPut 0x3400, outHi 0x0012, overflow=1; inReady=0 during BUSY.
- Divide: divu 100/7 → 14; remu 100/7 → 2, each after 17 edges; divu 5/0 → 0xFFFF, divByZero=1 after 1 edge.
- Reset mid-op and shift boundaries: assert resetN=0 at BUSY cycle 8 of a mult → no outValid, state IDLE. Shift amount 16 or 0xFFFF → 0 for 0101/0110, 0xFFFF for sra of 0x8000. Repeat the add test with WIDTH=32.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked, parametrised ALU with single-cycle logic/arith ops and
// iterative shift-add multiply / restoring unsigned divide.
module seq_alu #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outPut,
  output logic [WIDTH-1:0] outHi,
  output logic             isZero,
  output logic             carryOut,
  output logic             overflow,
  output logic             divByZero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpOr   = 4'h1;
  localparam logic [3:0] OpXor  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpNor  = 4'h4;
  localparam logic [3:0] OpSrl  = 4'h5;
  localparam logic [3:0] OpSll  = 4'h6;
  localparam logic [3:0] OpSub  = 4'h7;
  localparam logic [3:0] OpNand = 4'h8;
  localparam logic [3:0] OpMul  = 4'h9;
  localparam logic [3:0] OpDivu = 4'hA;
  localparam logic [3:0] OpRemu = 4'hB;
  localparam logic [3:0] OpSra  = 4'hC;
  localparam logic [3:0] OpSlt  = 4'hD;
  localparam logic [3:0] OpEq0  = 4'hE;
  localparam logic [3:0] OpSltu = 4'hF;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor
  logic [2*WIDTH-1:0] p_q;       // {acc/remainder, multiplier/quotient}
  logic [2*WIDTH-1:0] p_d;

  logic             valid_q, zero_q, carry_q, ovf_q, dz_q;
  logic [WIDTH-1:0] lo_q, hi_q;

  // single-cycle result path
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic               sh_big;
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH-1:0]   res_lo_d, res_hi_d;
  logic               res_c_d, res_v_d, res_dz_d;
  logic               start_multi;

  // iterative path
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] fin_lo_d, fin_hi_d;
  logic             fin_v_d;

  logic accept;

  assign inReady  = resetN && (state_q != StBusy) && (!valid_q || outReady);
  assign accept   = inValid && inReady;
  assign outValid = valid_q;
  assign outPut   = lo_q;
  assign outHi    = hi_q;
  assign isZero   = zero_q;
  assign carryOut = carry_q;
  assign overflow = ovf_q;
  assign divByZero = dz_q;

  // Result and flags for every op that completes on the accept edge.
  always_comb begin
    sum      = {1'b0, aIn} + {1'b0, bIn};
    diff     = aIn - bIn;
    prod     = {{WIDTH{1'b0}}, aIn} * {{WIDTH{1'b0}}, bIn};
    sh_big   = (bIn >= WIDTH'(WIDTH));
    sh_amt   = bIn[SHW-1:0];
    res_lo_d = '0;
    res_hi_d = '0;
    res_c_d  = 1'b0;
    res_v_d  = 1'b0;
    res_dz_d = 1'b0;
    unique case (aluOp)
      OpAdd: begin
        res_lo_d = sum[WIDTH-1:0];
        res_c_d  = sum[WIDTH];
        res_v_d  = (aIn[WIDTH-1] == bIn[WIDTH-1]) && (sum[WIDTH-1] != aIn[WIDTH-1]);
      end
      OpOr:   res_lo_d = aIn | bIn;
      OpXor:  res_lo_d = aIn ^ bIn;
      OpAnd:  res_lo_d = aIn & bIn;
      OpNor:  res_lo_d = ~(aIn | bIn);
      OpSrl:  res_lo_d = sh_big ? '0 : aIn >> sh_amt;
      OpSll:  res_lo_d = sh_big ? '0 : aIn << sh_amt;
      OpSub: begin
        res_lo_d = diff;
        res_c_d  = (aIn < bIn);
        res_v_d  = (aIn[WIDTH-1] != bIn[WIDTH-1]) && (diff[WIDTH-1] != aIn[WIDTH-1]);
      end
      OpNand: res_lo_d = ~(aIn & bIn);
      OpMul: begin
        res_lo_d = prod[WIDTH-1:0];
        res_hi_d = prod[2*WIDTH-1:WIDTH];
        res_v_d  = |prod[2*WIDTH-1:WIDTH];
      end
      // Only reached single-cycle when the divisor is zero.
      OpDivu: begin
        res_lo_d = '1;
        res_dz_d = (bIn == '0);
      end
      OpRemu: begin
        res_lo_d = aIn;
        res_dz_d = (bIn == '0);
      end
      OpSra:  res_lo_d = sh_big ? {WIDTH{aIn[WIDTH-1]}} : WIDTH'($signed(aIn) >>> sh_amt);
      OpSlt:  res_lo_d[0] = ($signed(aIn) < $signed(bIn));
      OpEq0:  res_lo_d[0] = (aIn == '0);
      OpSltu: res_lo_d[0] = (aIn < bIn);
    endcase
    start_multi = ((aluOp == OpMul) && (FAST_MUL == 0)) ||
                  (((aluOp == OpDivu) || (aluOp == OpRemu)) && (bIn != '0));
  end

  // One shift-add or restoring-divide step, plus the result the final step yields.
  always_comb begin
    msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : '0)};
    trial = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge    = (trial >= {1'b0, opnd_q});
    rem_n = ge ? (trial[WIDTH-1:0] - opnd_q) : trial[WIDTH-1:0];
    if (op_q == OpMul) begin
      p_d = {msum, p_q[WIDTH-1:1]};
    end else begin
      p_d = {rem_n, p_q[WIDTH-2:0], ge};
    end
    fin_lo_d = (op_q == OpRemu) ? p_d[2*WIDTH-1:WIDTH] : p_d[WIDTH-1:0];
    fin_hi_d = (op_q == OpMul) ? p_d[2*WIDTH-1:WIDTH] : '0;
    fin_v_d  = (op_q == OpMul) && (p_d[2*WIDTH-1:WIDTH] != '0);
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (valid_q && outReady) valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (start_multi) begin
              state_q <= StBusy;
              cnt_q   <= CW'(WIDTH);
              op_q    <= aluOp;
              opnd_q  <= (aluOp == OpMul) ? aIn : bIn;
              p_q     <= {{WIDTH{1'b0}}, ((aluOp == OpMul) ? bIn : aIn)};
            end else begin
              valid_q <= 1'b1;
              lo_q    <= res_lo_d;
              hi_q    <= res_hi_d;
              zero_q  <= (res_lo_d == '0);
              carry_q <= res_c_d;
              ovf_q   <= res_v_d;
              dz_q    <= res_dz_d;
            end
          end
        end
        StBusy: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          // Last step: counter hits 0 and the result loads on the same edge.
          if (cnt_q == CW'(1)) begin
            state_q <= StIdle;
            valid_q <= 1'b1;
            lo_q    <= fin_lo_d;
            hi_q    <= fin_hi_d;
            zero_q  <= (fin_lo_d == '0);
            carry_q <= 1'b0;
            ovf_q   <= fin_v_d;
            dz_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16 iterative, WIDTH=32 fast-mul).
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetN, inValid, outReady;
  logic [3:0]   aluOp;
  logic [W-1:0] aIn, bIn;
  logic         inReady, outValid, isZero, carryOut, overflow, divByZero;
  logic [W-1:0] outPut, outHi;

  logic         inValid32, outReady32;
  logic [3:0]   aluOp32;
  logic [31:0]  a32, b32;
  logic         inReady32, outValid32, isZero32, carry32, ovf32, dz32;
  logic [31:0]  out32, hi32;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W), .FAST_MUL(0)) u_dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady), .aluOp(aluOp),
    .aIn(aIn), .bIn(bIn), .outValid(outValid), .outReady(outReady), .outPut(outPut),
    .outHi(outHi), .isZero(isZero), .carryOut(carryOut), .overflow(overflow),
    .divByZero(divByZero)
  );

  seq_alu #(.WIDTH(32), .FAST_MUL(1)) u_dut32 (
    .clk(clk), .resetN(resetN), .inValid(inValid32), .inReady(inReady32), .aluOp(aluOp32),
    .aIn(a32), .bIn(b32), .outValid(outValid32), .outReady(outReady32), .outPut(out32),
    .outHi(hi32), .isZero(isZero32), .carryOut(carry32), .overflow(ovf32),
    .divByZero(dz32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {isZero, carryOut, overflow, divByZero}.
  task automatic chk_res(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic [3:0] flags);
    chk({tag, " valid"}, outValid, 1'b1);
    chk({tag, " out"}, outPut, lo);
    chk({tag, " hi"}, outHi, hi);
    chk({tag, " flags"}, {isZero, carryOut, overflow, divByZero}, flags);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    aluOp   = op;
    aIn     = a;
    bIn     = b;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  // Edges from accept (inclusive) until outValid; also reports any inReady while waiting.
  task automatic wait_out(output int n, output logic rdy_seen);
    n = 1;
    rdy_seen = 1'b0;
    while (!outValid && n < 100) begin
      rdy_seen = rdy_seen | inReady;
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          n;
    logic        rs;
    logic        seen;
    logic [3:0]  bb_op [4];
    logic [W-1:0] bb_a [4];
    logic [W-1:0] bb_b [4];
    logic [W-1:0] bb_e [4];

    resetN = 1'b0; inValid = 1'b1; outReady = 1'b1;
    aluOp = 4'h0; aIn = 16'h0001; bIn = 16'h0001;
    inValid32 = 1'b0; outReady32 = 1'b1; aluOp32 = 4'h0; a32 = '0; b32 = '0;

    // Reset held for 3 edges with inValid high
    repeat (3) tick();
    chk("rst inReady", inReady, 1'b0);
    chk("rst outValid", outValid, 1'b0);
    chk("rst outPut", outPut, 16'h0000);
    chk("rst outHi", outHi, 16'h0000);
    chk("rst flags", {isZero, carryOut, overflow, divByZero}, 4'b0000);
    resetN = 1'b1;
    #1;
    chk("post-rst inReady", inReady, 1'b1);
    tick();
    inValid = 1'b0;
    chk_res("first add", 16'h0002, 16'h0000, 4'b0000);

    // Add / sub flags
    issue(4'h0, 16'h7FFF, 16'h0001);
    chk_res("add ovf", 16'h8000, 16'h0000, 4'b0010);
    issue(4'h0, 16'hFFFF, 16'h0001);
    chk_res("add carry", 16'h0000, 16'h0000, 4'b1100);
    issue(4'h7, 16'h0003, 16'h0005);
    chk_res("sub borrow", 16'hFFFE, 16'h0000, 4'b0100);
    issue(4'h7, 16'h8000, 16'h0001);
    chk_res("sub ovf", 16'h7FFF, 16'h0000, 4'b0010);

    // Logic and compare ops
    issue(4'h1, 16'h0F00, 16'h00F0);
    chk_res("or", 16'h0FF0, 16'h0000, 4'b0000);
    issue(4'h3, 16'hFF0F, 16'h0FF0);
    chk_res("and", 16'h0F00, 16'h0000, 4'b0000);
    issue(4'h8, 16'hFFFF, 16'hFFFF);
    chk_res("nand", 16'h0000, 16'h0000, 4'b1000);
    issue(4'hE, 16'h0000, 16'h1234);
    chk_res("eq0", 16'h0001, 16'h0000, 4'b0000);
    issue(4'hF, 16'h0001, 16'hFFFF);
    chk_res("sltu t", 16'h0001, 16'h0000, 4'b0000);
    issue(4'hF, 16'hFFFF, 16'h0001);
    chk_res("sltu f", 16'h0000, 16'h0000, 4'b1000);
    issue(4'hD, 16'h0001, 16'hFFFF);
    chk_res("slt f", 16'h0000, 16'h0000, 4'b1000);

    // Back-to-back stream, then backpressure
    bb_op[0] = 4'h2; bb_a[0] = 16'h00FF; bb_b[0] = 16'h0F0F; bb_e[0] = 16'h0FF0;
    bb_op[1] = 4'h4; bb_a[1] = 16'h00F0; bb_b[1] = 16'h000F; bb_e[1] = 16'hFF00;
    bb_op[2] = 4'hC; bb_a[2] = 16'h8000; bb_b[2] = 16'h0004; bb_e[2] = 16'hF800;
    bb_op[3] = 4'hD; bb_a[3] = 16'hFFFF; bb_b[3] = 16'h0001; bb_e[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      aluOp = bb_op[i]; aIn = bb_a[i]; bIn = bb_b[i]; inValid = 1'b1;
      #1;
      chk($sformatf("b2b%0d inReady", i), inReady, 1'b1);
      tick();
      chk($sformatf("b2b%0d valid", i), outValid, 1'b1);
      chk($sformatf("b2b%0d out", i), outPut, bb_e[i]);
    end
    outReady = 1'b0;
    aluOp = 4'h0; aIn = 16'h0002; bIn = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d valid", i), outValid, 1'b1);
      chk($sformatf("hold%0d out", i), outPut, 16'h0001);
      chk($sformatf("hold%0d inReady", i), inReady, 1'b0);
    end
    outReady = 1'b1;
    #1;
    chk("release inReady", inReady, 1'b1);
    tick();
    inValid = 1'b0;
    chk_res("after hold add", 16'h0005, 16'h0000, 4'b0000);
    tick();
    chk("drain valid", outValid, 1'b0);

    // Iterative multiply
    issue(4'h9, 16'h1234, 16'h0100);
    wait_out(n, rs);
    chk("mul latency", n, 17);
    chk("mul busy inReady", rs, 1'b0);
    chk_res("mul 1234*0100", 16'h3400, 16'h0012, 4'b0010);
    issue(4'h9, 16'h0003, 16'h0005);
    wait_out(n, rs);
    chk("mul small latency", n, 17);
    chk_res("mul 3*5", 16'h000F, 16'h0000, 4'b0000);
    issue(4'h9, 16'hFFFF, 16'hFFFF);
    wait_out(n, rs);
    chk_res("mul ffff*ffff", 16'h0001, 16'hFFFE, 4'b0010);

    // Divide
    issue(4'hA, 16'd100, 16'd7);
    wait_out(n, rs);
    chk("divu latency", n, 17);
    chk_res("divu 100/7", 16'd14, 16'h0000, 4'b0000);
    issue(4'hB, 16'd100, 16'd7);
    wait_out(n, rs);
    chk("remu latency", n, 17);
    chk_res("remu 100/7", 16'd2, 16'h0000, 4'b0000);
    issue(4'hA, 16'hFFFF, 16'h0010);
    wait_out(n, rs);
    chk_res("divu ffff/10", 16'h0FFF, 16'h0000, 4'b0000);
    issue(4'hB, 16'hFFFF, 16'h0010);
    wait_out(n, rs);
    chk_res("remu ffff/10", 16'h000F, 16'h0000, 4'b0000);
    issue(4'hA, 16'd5, 16'd0);
    wait_out(n, rs);
    chk("div0 latency", n, 1);
    chk_res("divu 5/0", 16'hFFFF, 16'h0000, 4'b0001);
    issue(4'hB, 16'd9, 16'd0);
    wait_out(n, rs);
    chk_res("remu 9/0", 16'd9, 16'h0000, 4'b0001);

    // Reset during BUSY aborts the multiply
    issue(4'h9, 16'h1234, 16'h0100);
    repeat (8) tick();
    resetN = 1'b0;
    tick();
    chk("midrst valid", outValid, 1'b0);
    chk("midrst out", outPut, 16'h0000);
    chk("midrst inReady", inReady, 1'b0);
    resetN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      seen = seen | outValid;
    end
    chk("midrst no result", seen, 1'b0);
    chk("midrst idle", inReady, 1'b1);
    issue(4'h0, 16'h0001, 16'h0001);
    chk_res("midrst alive", 16'h0002, 16'h0000, 4'b0000);

    // Shift boundaries
    issue(4'h5, 16'h8000, 16'd16);
    chk_res("srl 16", 16'h0000, 16'h0000, 4'b1000);
    issue(4'h5, 16'h8000, 16'd15);
    chk_res("srl 15", 16'h0001, 16'h0000, 4'b0000);
    issue(4'h6, 16'h0001, 16'hFFFF);
    chk_res("sll ffff", 16'h0000, 16'h0000, 4'b1000);
    issue(4'h6, 16'h0001, 16'd15);
    chk_res("sll 15", 16'h8000, 16'h0000, 4'b0000);
    issue(4'hC, 16'h8000, 16'd16);
    chk_res("sra 16", 16'hFFFF, 16'h0000, 4'b0000);
    issue(4'hC, 16'h8000, 16'hFFFF);
    chk_res("sra ffff", 16'hFFFF, 16'h0000, 4'b0000);
    issue(4'hC, 16'h4000, 16'h0020);
    chk_res("sra pos big", 16'h0000, 16'h0000, 4'b1000);

    // WIDTH=32 instance: add overflow/carry and single-cycle multiply
    aluOp32 = 4'h0; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; inValid32 = 1'b1;
    tick();
    chk("w32 add ovf valid", outValid32, 1'b1);
    chk("w32 add ovf out", out32, 32'h8000_0000);
    chk("w32 add ovf flags", {isZero32, carry32, ovf32, dz32}, 4'b0010);
    a32 = 32'hFFFF_FFFF;
    tick();
    chk("w32 add carry out", out32, 32'h0000_0000);
    chk("w32 add carry flags", {isZero32, carry32, ovf32, dz32}, 4'b1100);
    aluOp32 = 4'h9; a32 = 32'h0001_0000; b32 = 32'h0001_0000;
    tick();
    inValid32 = 1'b0;
    chk("w32 fmul valid", outValid32, 1'b1);
    chk("w32 fmul lo", out32, 32'h0000_0000);
    chk("w32 fmul hi", hi32, 32'h0000_0001);
    chk("w32 fmul flags", {isZero32, carry32, ovf32, dz32}, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
